// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encodings, ALU op codes and width for the multiply sequencer
package mul_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int MUL_WIDTH = 32;

endpackage

// File: rtl/mul_seq.sv
// mul_seq: shift-add 32x32->64 unsigned multiplier that borrows the shared ALU for one ADD per cycle
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               alu_req,
    output logic [WIDTH-1:0]   alu_src_a,
    output logic [WIDTH-1:0]   alu_src_b,
    output logic [1:0]         alu_control,
    input  logic [WIDTH-1:0]   alu_result
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;
    logic [2*WIDTH-1:0] w_acc;
    logic               w_run;
    logic               w_last;
    logic               w_carry;

    assign w_run       = r_state == S_RUN;
    assign w_last      = r_cnt == CNT_W'(WIDTH - 1);
    assign alu_src_a   = w_run ? r_hi : '0;
    assign alu_src_b   = (w_run && r_lo[0]) ? r_mcand : '0;
    assign alu_control = ALU_ADD;
    // A 32-bit add wrapped around exactly when the sum is below an addend.
    assign w_carry     = alu_result < alu_src_a;
    // Partial product shifted right by one: carry lands in hi's MSB, sum's LSB enters lo.
    assign w_acc       = {w_carry, alu_result, r_lo[WIDTH-1:1]};
    assign busy        = r_state != S_IDLE;
    assign done        = r_state == S_DONE;
    assign alu_req     = w_run;
    assign product     = r_product;

    // Next-state logic: IDLE waits for start, RUN lasts WIDTH cycles, DONE lasts one.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Operand latch, shift-add iteration and final product capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_mcand <= op_a;
            r_lo    <= op_b;
            r_hi    <= '0;
            r_cnt   <= '0;
        end else if (w_run) begin
            {r_hi, r_lo} <= w_acc;
            r_cnt        <= r_cnt + 1'b1;
            if (w_last) r_product <= w_acc;
        end
    end

endmodule
